// File: rtl/adder_test_pkg.sv
// Shared definitions for the 4-bit adder test flow: default sizes, checker states
// and the {a,b,cin} vector layout used by the checker and its benches.
package adder_test_pkg;

  localparam int ADDER_WIDTH       = 4;
  localparam int ADDER_NUM_VECTORS = 512;
  localparam int ADDER_CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic                   cin;
  } vec_t;

endpackage

// File: rtl/adder_ref_model.sv
// Combinational reference adder: expected {cout,sum} for one operand vector.
module adder_ref_model
  import adder_test_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   expected
);

  assign expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_result_checker.sv
// Response checker for the adder test flow: compares each accepted vector with the
// reference model, counts vectors/mismatches and keeps the first failure.
// Define CHECKER_PIPE_EN to register the inputs one stage ahead of the compare.
module adder_result_checker
  import adder_test_pkg::*;
#(
  parameter int WIDTH       = ADDER_WIDTH,
  parameter int NUM_VECTORS = ADDER_NUM_VECTORS,
  parameter int CNT_W       = ADDER_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  input  logic [WIDTH-1:0]   sum,
  input  logic               cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   vec_count,
  output logic [CNT_W-1:0]   err_count,
  output logic               first_err_valid,
  output logic [2*WIDTH:0]   first_err_vec,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0]       S_IDLE   = ST_IDLE;
  localparam logic [1:0]       S_RUN    = ST_RUN;
  localparam logic [1:0]       S_DONE   = ST_DONE;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state;
  logic [CNT_W-1:0] acc_count;
  logic             drain;
  logic             accept;
  logic             accept_last;
  logic             start_take;

  logic             cmp_valid;
  logic             cmp_last;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_cin;
  logic [WIDTH-1:0] cmp_sum;
  logic             cmp_cout;
  logic [WIDTH:0]   expected;
  logic             mismatch;

  // Handshake: a vector transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on checker state, never on in_valid; the source may
  // raise or drop in_valid freely and the checker never stalls a run mid-way.
  assign in_ready    = (state == S_RUN) && !drain;
  assign accept      = in_valid && in_ready;
  assign accept_last = accept && (acc_count == LAST_IDX);
  assign start_take  = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef CHECKER_PIPE_EN
  logic             p_valid;
  logic             p_last;
  logic [WIDTH-1:0] p_a;
  logic [WIDTH-1:0] p_b;
  logic             p_cin;
  logic [WIDTH-1:0] p_sum;
  logic             p_cout;

  // drain closes in_ready after the final accept while that vector is still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_a     <= '0;
      p_b     <= '0;
      p_cin   <= 1'b0;
      p_sum   <= '0;
      p_cout  <= 1'b0;
      drain   <= 1'b0;
    end else begin
      p_valid <= accept;
      p_last  <= accept_last;
      if (accept) begin
        p_a    <= a;
        p_b    <= b;
        p_cin  <= cin;
        p_sum  <= sum;
        p_cout <= cout;
      end
      if (accept_last) begin
        drain <= 1'b1;
      end else if (p_valid && p_last) begin
        drain <= 1'b0;
      end
    end
  end

  assign cmp_valid = p_valid;
  assign cmp_last  = p_last;
  assign cmp_a     = p_a;
  assign cmp_b     = p_b;
  assign cmp_cin   = p_cin;
  assign cmp_sum   = p_sum;
  assign cmp_cout  = p_cout;
`else
  assign drain     = 1'b0;
  assign cmp_valid = accept;
  assign cmp_last  = accept_last;
  assign cmp_a     = a;
  assign cmp_b     = b;
  assign cmp_cin   = cin;
  assign cmp_sum   = sum;
  assign cmp_cout  = cout;
`endif

  adder_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a        (cmp_a),
    .b        (cmp_b),
    .cin      (cmp_cin),
    .expected (expected)
  );

  assign mismatch = cmp_valid && ({cmp_cout, cmp_sum} != expected);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      acc_count       <= '0;
      vec_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_RUN;
        S_RUN:   if (cmp_valid && cmp_last) state <= S_DONE;
        S_DONE:  if (start) state <= S_RUN;
        default: state <= S_IDLE;
      endcase

      if (start_take) begin
        acc_count       <= '0;
        vec_count       <= '0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_vec   <= '0;
      end else begin
        if (accept) acc_count <= acc_count + 1'b1;
        if (cmp_valid) vec_count <= vec_count + 1'b1;
        if (mismatch) begin
          if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_vec   <= {cmp_a, cmp_b, cmp_cin};
          end
        end
      end
    end
  end

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign pass      = done && (err_count == '0);
  assign state_dbg = state;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker with a per-vector scoreboard.
// Define CHECKER_PIPE_EN for both bench and RTL to exercise the registered-input build.
module tb_adder_result_checker;
  import adder_test_pkg::*;

  localparam int W = 10;  // {mismatch, a[3:0], b[3:0], cin}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  a = '0;
  logic [3:0]  b = '0;
  logic        cin = 1'b0;
  logic [3:0]  sum = '0;
  logic        cout = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] vec_count;
  logic [15:0] err_count;
  logic        first_err_valid;
  logic [8:0]  first_err_vec;
  logic [1:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] prev_vc = '0;
  logic [15:0] m_vec   = '0;
  logic [15:0] m_err   = '0;
  logic        m_fv    = 1'b0;
  logic [8:0]  m_fe    = '0;

  adder_result_checker dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .a               (a),
    .b               (b),
    .cin             (cin),
    .sum             (sum),
    .cout            (cout),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .vec_count       (vec_count),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_vec   (first_err_vec),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_raw(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                          input logic [3:0] vs, input logic vco);
    logic [4:0] ref_r;
    logic       mis;
    int         tries;
    ref_r = 5'(va) + 5'(vb) + 5'(vc);
    mis   = ({vco, vs} != ref_r);
    a = va; b = vb; cin = vc; sum = vs; cout = vco;
    in_valid = 1'b1;
    tries = 0;
    while (in_ready !== 1'b1 && tries < 20) begin
      step();
      tries++;
    end
    if (in_ready !== 1'b1) begin
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    end else begin
      exp_q.push_back({mis, va, vb, vc});
      n_vec++;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_idx(input int idx, input logic corrupt);
    logic [8:0] iv;
    logic [4:0] r;
    iv = 9'(idx);
    r  = 5'(iv[8:5]) + 5'(iv[4:1]) + 5'(iv[0]);
    if (corrupt) r[0] = ~r[0];
    send_raw(iv[8:5], iv[4:1], iv[0], r[3:0], r[4]);
  endtask

  // called one cycle-fraction after the final accept edge; also presents an extra vector
  task automatic end_check(input string tag, input logic [15:0] e_err, input logic e_fv,
                           input logic [8:0] e_fe, input logic e_pass);
    in_valid = 1'b1;
    check({tag, "_in_ready_drop"}, {31'd0, in_ready}, 32'd0);
`ifdef CHECKER_PIPE_EN
    check({tag, "_done_pipe_lat"}, {31'd0, done}, 32'd0);
    step();
`endif
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, {31'd0, e_pass});
    check({tag, "_vec_count"}, {16'd0, vec_count}, 32'd512);
    check({tag, "_err_count"}, {16'd0, err_count}, {16'd0, e_err});
    check({tag, "_first_err_valid"}, {31'd0, first_err_valid}, {31'd0, e_fv});
    check({tag, "_first_err_vec"}, {23'd0, first_err_vec}, {23'd0, e_fe});
    step();
    step();
    in_valid = 1'b0;
    check({tag, "_ignore_after_done"}, {16'd0, vec_count}, 32'd512);
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  // scoreboard: each change of vec_count retires one expected vector
  always @(negedge clk) begin
    if (!rst && vec_count !== prev_vc) begin
      if (vec_count === 16'd0) begin
        m_vec = '0;
        m_err = '0;
        m_fv  = 1'b0;
        m_fe  = '0;
      end else if (exp_q.size() == 0) begin
        check("sb_unexpected_count", {16'd0, vec_count}, {16'd0, m_vec});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        m_vec++;
        if (e[9]) begin
          if (m_err != 16'hFFFF) m_err++;
          if (!m_fv) begin
            m_fv = 1'b1;
            m_fe = e[8:0];
          end
        end
        check("sb_vec_count", {16'd0, vec_count}, {16'd0, m_vec});
        check("sb_err_count", {16'd0, err_count}, {16'd0, m_err});
        check("sb_first_err_valid", {31'd0, first_err_valid}, {31'd0, m_fv});
        if (m_fv) check("sb_first_err_vec", {23'd0, first_err_vec}, {23'd0, m_fe});
      end
      prev_vc = vec_count;
    end
  end

  initial begin
    vec_t v;
    int   sent;

    // reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_first_err_valid", {31'd0, first_err_valid}, 32'd0);
    check("rst_vec_count", {16'd0, vec_count}, 32'd0);
    check("rst_err_count", {16'd0, err_count}, 32'd0);
    check("rst_first_err_vec", {23'd0, first_err_vec}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // valid in IDLE is ignored
    in_valid = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    check("idle_ignore_valid", {16'd0, vec_count}, 32'd0);

    // 1: exhaustive clean sweep
    pulse_start();
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 512; i++) send_idx(i, 1'b0);
    end_check("t1", 16'd0, 1'b0, 9'd0, 1'b1);

    // 2: single wrong result at a=7 b=9 cin=1, entered from DONE
    pulse_start();
    check("t6_busy", {31'd0, busy}, 32'd1);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_vec_cleared", {16'd0, vec_count}, 32'd0);
    v.a = 4'h7; v.b = 4'h9; v.cin = 1'b1;
    for (int i = 0; i < 512; i++) begin
      if (9'(i) == 9'(v)) send_raw(v.a, v.b, v.cin, 4'h0, 1'b0);
      else send_idx(i, 1'b0);
    end
    end_check("t2", 16'd1, 1'b1, 9'(v), 1'b0);

    // 3: errors at vectors 10 and 20; first capture must stick
    pulse_start();
    check("t6b_err_cleared", {16'd0, err_count}, 32'd0);
    check("t6b_fev_cleared", {31'd0, first_err_valid}, 32'd0);
    check("t6b_fe_cleared", {23'd0, first_err_vec}, 32'd0);
    check("t6b_pass_cleared", {31'd0, pass}, 32'd0);
    for (int i = 0; i < 512; i++) send_idx(i, (i == 10) || (i == 20));
    end_check("t3", 16'd2, 1'b1, 9'd10, 1'b0);

    // 4: reset in the middle of a run
    pulse_start();
    for (int i = 0; i < 100; i++) send_idx(i, (i == 50));
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("t4_state", {30'd0, state_dbg}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_in_ready", {31'd0, in_ready}, 32'd0);
    check("t4_vec_count", {16'd0, vec_count}, 32'd0);
    check("t4_err_count", {16'd0, err_count}, 32'd0);
    check("t4_first_err_valid", {31'd0, first_err_valid}, 32'd0);
    pulse_start();
    check("t4_restart_busy", {31'd0, busy}, 32'd1);
    send_idx(0, 1'b0);
`ifdef CHECKER_PIPE_EN
    check("t4_pipe_lat", {16'd0, vec_count}, 32'd0);
    step();
`endif
    check("t4_first_count", {16'd0, vec_count}, 32'd1);

    // 5: gapped valid with a start pulse mid-run (ignored)
    sent = 1;
    for (int i = 1; i < 512; i++) begin
      send_idx(i, 1'b0);
      sent++;
      if (i == 200) begin
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t5_start_ignored_busy", {31'd0, busy}, 32'd1);
        check("t5_start_ignored_count", {16'd0, vec_count}, sent);
      end else if (i != 511) begin
        step();
      end
    end
    end_check("t5", 16'd0, 1'b0, 9'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
